// File: rtl/divider_seq_param.sv
// Sequential restoring divider, one quotient bit per clock, with signed mode,
// busy/done handshake, divide-by-zero fast path and signed-overflow flag.
module divider_seq_param #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             dzo_q, dzo_d;
    logic             ovo_q, ovo_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;

    assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        y_d     = y_q;
        rout_d  = rout_q;
        dzo_d   = dzo_q;
        ovo_d   = ovo_q;
        shifted = {rem_q, quo_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    dz_d   = (b == '0);
                    // The zero-divisor path keeps the raw dividend for the remainder output.
                    quo_d  = (b == '0) ? a : a_mag;
                    dvs_d  = b_mag;
                    rem_d  = '0;
                    cnt_d  = CW'(WIDTH);
                    negq_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    negr_d = signed_mode & a[WIDTH-1];
                    ov_d   = signed_mode && (a == MOST_NEG) && (b == '1);
                    state_d = (b == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (shifted >= {1'b0, dvs_q}) begin
                    rem_d = shifted[WIDTH-1:0] - dvs_q;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_q) begin
                    y_d    = '1;
                    rout_d = quo_q;
                    dzo_d  = 1'b1;
                    ovo_d  = 1'b0;
                end else begin
                    y_d    = negq_q ? -quo_q : quo_q;
                    rout_d = negr_q ? -rem_q : rem_q;
                    dzo_d  = 1'b0;
                    ovo_d  = ov_q;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            rout_q  <= '0;
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            rout_q  <= rout_d;
            dzo_q   <= dzo_d;
            ovo_q   <= ovo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign y           = y_q;
    assign remainder   = rout_q;
    assign div_by_zero = dzo_q;
    assign overflow    = ovo_q;

endmodule
